// File: rtl/rr_slice_requester.sv
// ----------------------------------------------------------------------------
// rr_slice_requester
//
// Purpose:
//   Four per-client FIFOs that feed one shared bus through an external
//   round-robin, fixed-time-slice arbiter. Each non-empty FIFO raises a
//   registered request line. While the arbiter holds a legal one-hot grant,
//   the granted FIFO pops one word per cycle. Each popped word is presented
//   on the shared bus one cycle after the pop.
//
// Ports:
//   clk        input   1          single clock, rising edge
//   rst        input   1          asynchronous active-high reset
//   in_valid   input   4          per-client push strobe
//   in_ready   output  4          per-client FIFO-not-full
//   in_data    input   4*DATA_W   client i word on [i*DATA_W +: DATA_W]
//   REQ        output  4          registered request lines to the arbiter
//   GNT        input   4          one-hot grant, held for a time slice
//   bus_valid  output  1          shared-bus beat valid
//   bus_data   output  DATA_W     shared-bus beat data
//   bus_id     output  2          client index owning the current beat
//   err        output  2          sticky grant-protocol error flags
//
// Optional feature:
//   RR_GNT_CHECK_EN - when defined, builds the grant protocol checker.
//                     err[0] is set by a multi-hot grant.
//                     err[1] is set by a grant to a client that is not
//                     requesting.
//                     When undefined, err is tied to zero.
// ----------------------------------------------------------------------------
module rr_slice_requester #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    output logic [3:0]          in_ready,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          REQ,
    input  logic [3:0]          GNT,
    output logic                bus_valid,
    output logic [DATA_W-1:0]   bus_data,
    output logic [1:0]          bus_id,
    output logic [1:0]          err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q  [4][DEPTH];
    logic [PTR_W-1:0]  wptr_q [4];
    logic [PTR_W-1:0]  rptr_q [4];
    logic [CNT_W-1:0]  count_q [4];
    logic [CNT_W-1:0]  count_d [4];

    logic [3:0]        req_q;
    logic              busValid_q;
    logic [DATA_W-1:0] busData_q;
    logic [1:0]        busId_q;

    logic [3:0]        push;
    logic [3:0]        pop;
    logic              gntOneHot;
    logic [1:0]        popIdx;
    logic [DATA_W-1:0] popData;

    // The full check uses only the current count. A pop in the same cycle
    // does not allow a push into a full FIFO.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_ready[i] = (count_q[i] < CNT_W'(DEPTH));
            push[i]     = in_valid[i] && in_ready[i];
        end
    end

    // Only a single-bit grant is honoured. A zero or multi-hot grant pops
    // nothing. A grant to an empty FIFO also pops nothing.
    assign gntOneHot = (GNT != 4'd0) && ((GNT & (GNT - 4'd1)) == 4'd0);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pop[i] = gntOneHot && GNT[i] && (count_q[i] != '0);
        end
    end

    // At most one pop can be active, so a priority scan is sufficient to
    // encode the popping client and select its head word.
    always_comb begin
        popIdx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                popIdx = 2'(i);
            end
        end
        popData = mem_q[popIdx][rptr_q[popIdx]];
    end

    // Next occupancy. If a push and a pop hit the same FIFO in one cycle,
    // the count is unchanged.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            count_d[i] = count_q[i];
            if (push[i] && !pop[i]) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end else if (pop[i] && !push[i]) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end
        end
    end

    // Pointers, counts, request lines and the bus beat register.
    // A reset flushes every queue. Stale storage contents are never read
    // afterwards, because the counts restart at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
            req_q      <= 4'd0;
            busValid_q <= 1'b0;
            busData_q  <= '0;
            busId_q    <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                count_q[i] <= count_d[i];
                req_q[i]   <= (count_d[i] != '0);
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + PTR_W'(1);
                end
            end
            busValid_q <= |pop;
            if (|pop) begin
                busData_q <= popData;
                busId_q   <= popIdx;
            end
        end
    end

    // Word storage has no reset. Pointer wrap falls out of the
    // power-of-two depth.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign REQ       = req_q;
    assign bus_valid = busValid_q;
    assign bus_data  = busData_q;
    assign bus_id    = busId_q;

`ifdef RR_GNT_CHECK_EN
    logic [1:0] err_q;
    logic       gntMultiHot;

    assign gntMultiHot = ((GNT & (GNT - 4'd1)) != 4'd0);

    // Sticky protocol flags. Only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 2'b00;
        end else begin
            if (gntMultiHot) begin
                err_q[0] <= 1'b1;
            end
            if ((GNT & ~req_q) != 4'd0) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

endmodule
